rx: RTL and testbench

- Channel receiver: the stage directly downstream of the link transmitter.
- Accepts flits over a two-phase (toggle) bundled-data req/ack channel and writes each flit into the input packet buffer.
- Once a full packet (2^BUFF_BITS flits) is stored, presents it to the switch allocator with a valid/ack handshake.
- Back-pressures the channel until the buffer is released.

---
 rtl/rx_pkg.sv | 14 +
 rtl/rx_sync.sv | 24 ++
 rtl/rx.sv | 143 ++++++++++++++
 tb/tb_rx.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types for the channel receiver (rx) and its request synchronizer.
package rx_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE           = 3'b000,
        ST_RECEIVING      = 3'b001,
        ST_FULL           = 3'b010,
        ST_WAIT_DONE_DOWN = 3'b011
    } state_t;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit level (ch_req).
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift chain, cleared by the async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= '0;
        end else begin
            ff <= (ff << 1) | STAGES'(d);
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/rx.sv
// Channel receiver: accepts flits over a two-phase req/ack channel, writes
// them into the packet buffer and hands a full packet to the switch.
// Optional statistics counters are built when RX_STATS_EN is defined.
module rx
    import rx_pkg::*;
#(
    parameter int ID            = 0,
    parameter int SUBID         = 0,
    parameter int SIZE          = 8,
    parameter int BUFF_BITS     = 3,
    parameter int VERBOSE_DEBUG = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ch_req,
    input  logic [SIZE-1:0]      ch_flit,
    output logic                 ch_ack,
    output logic                 buf_wr,
    output logic [BUFF_BITS-1:0] buf_addr,
    output logic [SIZE-1:0]      buf_data,
    output logic                 pkt_valid,
    input  logic                 pkt_done
`ifdef RX_STATS_EN
    ,
    output logic [STAT_W-1:0]    pkt_count,
    output logic [STAT_W-1:0]    flit_count
`endif
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   req_sync;
    logic                   req_old;
    logic                   req;
    logic                   accept;
    logic                   pkt_valid_nxt;
    logic [BUFF_BITS-1:0]   flit_counter;

    // Debug identifiers have no hardware meaning; tie them off
    wire unused_dbg = ^{32'(ID), 32'(SUBID), 32'(VERBOSE_DEBUG)};

    rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ch_req),
        .q     (req_sync)
    );

    // A toggle stays pending until req_old catches up on acceptance
    assign req = req_sync ^ req_old;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, acceptance and packet-valid decode
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        pkt_valid_nxt = pkt_valid;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = ST_RECEIVING;
                end
            end
            ST_RECEIVING: begin
                if (req) begin
                    accept = 1'b1;
                    if (flit_counter == '1) begin
                        state_nxt     = ST_FULL;
                        pkt_valid_nxt = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (pkt_done) begin
                    pkt_valid_nxt = 1'b0;
                    state_nxt     = ST_WAIT_DONE_DOWN;
                end
            end
            ST_WAIT_DONE_DOWN: begin
                if (!pkt_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                pkt_valid_nxt = 1'b0;
            end
        endcase
    end

    // Flit write, ack toggle and address counter, all on the acceptance edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_ack       <= 1'b0;
            buf_wr       <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
            pkt_valid    <= 1'b0;
            flit_counter <= '0;
            req_old      <= 1'b0;
        end else begin
            buf_wr    <= accept;
            pkt_valid <= pkt_valid_nxt;
            if (accept) begin
                buf_addr     <= flit_counter;
                buf_data     <= ch_flit;
                ch_ack       <= ~ch_ack;
                flit_counter <= flit_counter + BUFF_BITS'(1);
                req_old      <= req_sync;
            end
        end
    end

`ifdef RX_STATS_EN
    // Packet and flit counters, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count  <= '0;
            flit_count <= '0;
        end else begin
            if (accept) begin
                flit_count <= flit_count + STAT_W'(1);
            end
            if ((state_nxt == ST_FULL) && (state != ST_FULL)) begin
                pkt_count <= pkt_count + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: randomized flits against a queue-based model.
module tb_rx;

    localparam int SIZE = 8;
    localparam int BB   = 3;
    localparam int SS   = 2;
    localparam int PKT  = 1 << BB;

    logic            clk = 1'b0;
    logic            reset;
    logic            ch_req;
    logic [SIZE-1:0] ch_flit;
    logic            ch_ack;
    logic            buf_wr;
    logic [BB-1:0]   buf_addr;
    logic [SIZE-1:0] buf_data;
    logic            pkt_valid;
    logic            pkt_done;
`ifdef RX_STATS_EN
    logic [15:0]     pkt_count;
    logic [15:0]     flit_count;
`endif

    always #5 clk = ~clk;

    rx #(
        .ID(0), .SUBID(0), .SIZE(SIZE), .BUFF_BITS(BB),
        .VERBOSE_DEBUG(0), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_flit(ch_flit),
        .ch_ack(ch_ack), .buf_wr(buf_wr), .buf_addr(buf_addr),
        .buf_data(buf_data), .pkt_valid(pkt_valid), .pkt_done(pkt_done)
`ifdef RX_STATS_EN
        , .pkt_count(pkt_count), .flit_count(flit_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Observed writes and model-expected writes, each {addr, data}
    logic [BB+SIZE-1:0] wr_q[$];
    logic [BB+SIZE-1:0] exp_q[$];
    int valid_cycles = 0;
    int m_cnt = 0;
    int exp_pkts = 0;
    int exp_flits = 0;

    // Advance n cycles, sampling DUT outputs on the falling edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (buf_wr === 1'b1) wr_q.push_back({buf_addr, buf_data});
            if (pkt_valid === 1'b1) valid_cycles++;
        end
    endtask

    // Model: flit k of the stream lands at address k mod packet length
    task automatic model_flit(input logic [SIZE-1:0] d);
        exp_q.push_back({BB'(m_cnt % PKT), d});
        m_cnt++;
        exp_flits++;
        if (m_cnt % PKT == 0) exp_pkts++;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        exp_pkts = 0;
        exp_flits = 0;
        exp_q.delete();
        wr_q.delete();
    endtask

    // Toggle req with new data and wait (bounded) for the matching ack phase
    task automatic send_flit(input logic [SIZE-1:0] d, output int lat);
        ch_flit = d;
        ch_req  = ~ch_req;
        lat = 0;
        while (ch_ack !== ch_req && lat < 40) begin
            cyc(1);
            lat++;
        end
    endtask

    task automatic run_flits(input int n, input bit gaps, output int tmo);
        logic [SIZE-1:0] d;
        int lat;
        tmo = 0;
        for (int i = 0; i < n; i++) begin
            d = SIZE'($urandom);
            if (gaps) cyc(int'($urandom_range(0, 4)));
            send_flit(d, lat);
            if (ch_ack !== ch_req) tmo++;
            model_flit(d);
        end
    endtask

    task automatic release_pkt();
        int n;
        pkt_done = 1'b1;
        n = 0;
        while (pkt_valid !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        checks++;
        if (pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: pkt_valid=%b want 0", pkt_valid);
        end
        pkt_done = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        reset = 1'b0; ch_req = 1'b0; ch_flit = '0; pkt_done = 1'b0;
        cyc(3);
        checks++;
        if ({ch_ack, buf_wr, buf_addr, buf_data, pkt_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b wr=%b addr=%0d data=%h valid=%b want all 0",
                     ch_ack, buf_wr, buf_addr, buf_data, pkt_valid);
        end
        reset = 1'b1;
        cyc(2);
        checks++;
        if (wr_q.size() != 0 || ch_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: writes=%0d ack=%b want 0 0", wr_q.size(), ch_ack);
        end
        model_reset();
    endtask

    task automatic test_packet();
        int lat;
        logic [BB+SIZE-1:0] got, want;
        for (int i = 0; i < PKT; i++) begin
            if (i == PKT - 1) begin
                checks++;
                if (pkt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL pkt_early_valid: pkt_valid=%b want 0", pkt_valid);
                end
            end
            send_flit(SIZE'(8'h10 + i), lat);
            model_flit(SIZE'(8'h10 + i));
        end
        checks++;
        if (ch_ack !== 1'b0 || pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL pkt_end: ack=%b valid=%b want 0 1", ch_ack, pkt_valid);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pkt_writes: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL pkt_data: got %h want %h", got, want);
            end
        end
        release_pkt();
    endtask

    task automatic test_latency();
        int lat, tmo;
        logic [BB+SIZE-1:0] got, want;
        send_flit(8'h5A, lat);
        model_flit(8'h5A);
        checks++;
        if (lat != SS + 1) begin
            errors++;
            $display("FAIL latency: got %0d edges want %0d", lat, SS + 1);
        end
        run_flits(PKT - 1, 1'b0, tmo);
        checks++;
        if (tmo != 0 || pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat_pkt: timeouts=%0d valid=%b want 0 1", tmo, pkt_valid);
        end
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lat_data: got %h want %h", got, want);
            end
        end
        release_pkt();
    endtask

    task automatic test_backpressure();
        int tmo, n;
        logic [BB+SIZE-1:0] got, want;
        logic ack_before;
        run_flits(PKT, 1'b1, tmo);
        checks++;
        if (tmo != 0 || wr_q.size() != PKT) begin
            errors++;
            $display("FAIL bp_fill: timeouts=%0d writes=%0d want 0 %0d", tmo, wr_q.size(), PKT);
        end
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bp_data: got %h want %h", got, want);
            end
        end
        ack_before = ch_ack;
        ch_flit = 8'hA0;
        ch_req  = ~ch_req;
        cyc(50);
        checks++;
        if (wr_q.size() != 0 || ch_ack !== ack_before || pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: writes=%0d ack=%b valid=%b want 0 %b 1",
                     wr_q.size(), ch_ack, pkt_valid, ack_before);
        end
        pkt_done = 1'b1;
        cyc(3);
        checks++;
        if (pkt_valid !== 1'b0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL bp_done: valid=%b writes=%0d want 0 0", pkt_valid, wr_q.size());
        end
        pkt_done = 1'b0;
        model_flit(8'hA0);
        n = 0;
        while (ch_ack !== ch_req && n < 20) begin
            cyc(1);
            n++;
        end
        checks++;
        if (wr_q.size() != 1 || ch_ack !== ch_req) begin
            errors++;
            $display("FAIL bp_resume: writes=%0d ack=%b want 1 %b", wr_q.size(), ch_ack, ch_req);
        end else begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want || got !== {BB'(0), 8'hA0}) begin
                errors++;
                $display("FAIL bp_first: got %h want %h", got, want);
            end
        end
        run_flits(PKT - 1, 1'b1, tmo);
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bp_rest: got %h want %h", got, want);
            end
        end
        release_pkt();
    endtask

    task automatic test_done_held();
        int tmo, v0, n;
        logic [BB+SIZE-1:0] got, want;
        pkt_done = 1'b1;
        run_flits(PKT, 1'b0, tmo);
        v0 = valid_cycles;
        cyc(4);
        checks++;
        if (valid_cycles - v0 != 0 || pkt_valid !== 1'b0 || tmo != 0) begin
            errors++;
            $display("FAIL held_valid: extra valid cycles=%0d valid=%b tmo=%0d want 0 0 0",
                     valid_cycles - v0, pkt_valid, tmo);
        end
        checks++;
        if (valid_cycles < 1) begin
            errors++;
            $display("FAIL held_pulse: valid cycles=%0d want >=1", valid_cycles);
        end
        ch_flit = 8'hC3;
        ch_req  = ~ch_req;
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL held_data: got %h want %h", got, want);
            end
        end
        cyc(20);
        checks++;
        if (wr_q.size() != 0 || ch_ack === ch_req) begin
            errors++;
            $display("FAIL held_wait: writes=%0d ack=%b want 0 and not %b", wr_q.size(), ch_ack, ch_req);
        end
        pkt_done = 1'b0;
        model_flit(8'hC3);
        n = 0;
        while (ch_ack !== ch_req && n < 20) begin
            cyc(1);
            n++;
        end
        run_flits(PKT - 1, 1'b1, tmo);
        checks++;
        if (wr_q.size() != exp_q.size() || pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL held_next: writes=%0d valid=%b want %0d 1", wr_q.size(), pkt_valid, exp_q.size());
        end
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL held_next_data: got %h want %h", got, want);
            end
        end
        release_pkt();
    endtask

    task automatic test_reset_mid();
        int tmo;
        logic [BB+SIZE-1:0] got, want;
        run_flits(3, 1'b1, tmo);
        reset = 1'b0; ch_req = 1'b0; pkt_done = 1'b0;
        cyc(2);
        checks++;
        if ({ch_ack, buf_wr, buf_addr, buf_data, pkt_valid} !== '0) begin
            errors++;
            $display("FAIL mid_reset: ack=%b wr=%b addr=%0d data=%h valid=%b want all 0",
                     ch_ack, buf_wr, buf_addr, buf_data, pkt_valid);
        end
`ifdef RX_STATS_EN
        checks++;
        if (pkt_count !== 16'd0 || flit_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_stats: pkts=%0d flits=%0d want 0 0", pkt_count, flit_count);
        end
`endif
        reset = 1'b1;
        cyc(2);
        model_reset();
        run_flits(PKT, 1'b1, tmo);
        checks++;
        if (wr_q.size() != PKT || pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: writes=%0d valid=%b want %0d 1", wr_q.size(), pkt_valid, PKT);
        end
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_data: got %h want %h", got, want);
            end
        end
        release_pkt();
    endtask

    task automatic test_random();
        int tmo;
        logic [BB+SIZE-1:0] got, want;
        for (int p = 0; p < 3; p++) begin
            run_flits(PKT, 1'b1, tmo);
            checks++;
            if (tmo != 0 || pkt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_pkt%0d: timeouts=%0d valid=%b want 0 1", p, tmo, pkt_valid);
            end
            cyc(int'($urandom_range(0, 10)));
            release_pkt();
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_writes: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        while (wr_q.size() > 0 && exp_q.size() > 0) begin
            got = wr_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rand_data: got %h want %h", got, want);
            end
        end
    endtask

`ifdef RX_STATS_EN
    task automatic test_stats();
        checks++;
        if (pkt_count !== 16'(exp_pkts) || flit_count !== 16'(exp_flits)) begin
            errors++;
            $display("FAIL stats: pkts=%0d flits=%0d want %0d %0d",
                     pkt_count, flit_count, exp_pkts, exp_flits);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; ch_req = 1'b0; ch_flit = '0; pkt_done = 1'b0;
        test_reset();
        test_packet();
        test_latency();
        test_backpressure();
        test_done_held();
        test_reset_mid();
        test_random();
`ifdef RX_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
